// File: rtl/nn_fixed_pkg.sv
// Fixed-point helpers and FSM state type shared by the backprop engine stages.
package nn_fixed_pkg;

  // Working width for rounding/saturation; wide enough for any product+accumulate here.
  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef enum logic [1:0] {IDLE, MAC, SCALE, DONE} state_t;

  // Fixed-point 1.0 for a given number of fractional bits.
  function automatic int one_q(input int frac);
    return 1 << frac;
  endfunction

  // Round half up, then drop frac fractional bits (arithmetic shift).
  function automatic wide_t rnd(input wide_t x, input int frac);
    wide_t half;
    half = wide_t'(1) <<< (frac - 1);
    return (x + half) >>> frac;
  endfunction

  // Clamp to the signed range of a w-bit two's complement number.
  function automatic wide_t sat(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/hidden_delta_engine_if.sv
// Request/result bundle between the output-delta stage, this engine and the weight-update stage.
interface hidden_delta_engine_if #(
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int W     = 10
);
  localparam int IDX_W = (N_HID > 1) ? $clog2(N_HID) : 1;

  logic                 start;
  logic signed [W-1:0]  delta1  [N_OUT];
  logic signed [W-1:0]  weight  [N_OUT][N_HID];
  logic        [W-1:0]  out_cal [N_HID];
  logic                 busy;
  logic                 res_valid;
  logic [IDX_W-1:0]     res_idx;
  logic signed [W-1:0]  delta0  [N_HID];
  logic [N_HID-1:0]     sign0;
  logic                 done;

  modport master (
    output start, delta1, weight, out_cal,
    input  busy, res_valid, res_idx, delta0, sign0, done
  );

  modport slave (
    input  start, delta1, weight, out_cal,
    output busy, res_valid, res_idx, delta0, sign0, done
  );
endinterface

// File: rtl/sigmoid_prime_q.sv
// Sigmoid derivative out*(ONE-out) in fixed point; activations above ONE are clamped to ONE.
module sigmoid_prime_q
  import nn_fixed_pkg::*;
#(
  parameter int W    = 10,
  parameter int FRAC = 8
) (
  input  logic        [W-1:0] i_out,
  output logic signed [W-1:0] o_sp
);

  localparam logic [W-1:0] ONE_Q = W'(one_q(FRAC));

  logic [W-1:0]   w_c;
  logic [W-1:0]   w_rem;
  logic [2*W-1:0] w_p;

  // Clamp, form the unsigned product and round back to W bits (result never exceeds ONE/4).
  always_comb begin
    w_c   = (i_out > ONE_Q) ? ONE_Q : i_out;
    w_rem = ONE_Q - w_c;
    w_p   = {{W{1'b0}}, w_c} * {{W{1'b0}}, w_rem};
    o_sp  = W'(rnd(wide_t'(w_p), FRAC));
  end

endmodule

// File: rtl/hidden_delta_engine.sv
// Hidden-layer backprop delta engine: one time-shared multiplier walks k for each neuron j,
// then reuses the same multiplier to scale the rounded sum by the sigmoid derivative.
module hidden_delta_engine
  import nn_fixed_pkg::*;
#(
  parameter int N_HID = 5,
  parameter int N_OUT = 3,
  parameter int W     = 10,
  parameter int FRAC  = 8
) (
  input logic             clk,
  input logic             rst,
  hidden_delta_engine_if.slave bus
);

  localparam int K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int J_W   = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int ACC_W = 2*W + $clog2(N_OUT);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_OUT - 1);
  localparam logic [J_W-1:0] J_LAST = J_W'(N_HID - 1);

  state_t r_state, w_next;

  logic [K_W-1:0]        r_k;
  logic [J_W-1:0]        r_j;
  logic signed [W-1:0]   r_d1 [N_OUT];
  logic signed [W-1:0]   r_w  [N_OUT][N_HID];
  logic        [W-1:0]   r_oc [N_HID];
  logic signed [ACC_W-1:0] r_acc;
  logic signed [W-1:0]   r_delta0 [N_HID];
  logic                  r_res_valid;
  logic [J_W-1:0]        r_res_idx;

  logic                  w_accept;
  logic                  w_last_k;
  logic                  w_last_j;
  logic signed [W-1:0]   w_sp;
  logic signed [W-1:0]   w_s;
  logic signed [W-1:0]   w_ma;
  logic signed [W-1:0]   w_mb;
  logic signed [2*W-1:0] w_prod;
  logic signed [W-1:0]   w_d0_new;

  assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last_k = (r_k == K_LAST);
  assign w_last_j = (r_j == J_LAST);

  sigmoid_prime_q #(.W(W), .FRAC(FRAC)) u_sp (
    .i_out (r_oc[r_j]),
    .o_sp  (w_sp)
  );

  // State register; reset wins over a same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: MAC over k, one SCALE per neuron, one DONE cycle that can re-accept.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MAC;
      MAC:     if (w_last_k) w_next = SCALE;
      SCALE:   w_next = w_last_j ? DONE : MAC;
      DONE:    w_next = w_accept ? MAC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Shared multiplier: delta1*weight while accumulating, s*sp while scaling.
  always_comb begin
    w_s  = W'(sat(rnd(wide_t'(r_acc), FRAC), W));
    w_ma = r_d1[r_k];
    w_mb = r_w[r_k][r_j];
    if (r_state == SCALE) begin
      w_ma = w_s;
      w_mb = w_sp;
    end
    w_prod   = (2*W)'(w_ma) * (2*W)'(w_mb);
    w_d0_new = W'(sat(rnd(wide_t'(w_prod), FRAC), W));
  end

  // Operand snapshot taken at accept so later input changes cannot disturb the run.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_d1 <= bus.delta1;
      r_w  <= bus.weight;
      r_oc <= bus.out_cal;
    end
  end

  // Accumulator, loop counters and result array.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_k         <= '0;
      r_j         <= '0;
      r_res_valid <= 1'b0;
      r_res_idx   <= '0;
      for (int j = 0; j < N_HID; j++) r_delta0[j] <= '0;
    end else begin
      r_res_valid <= 1'b0;
      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
        r_j   <= '0;
      end else begin
        case (r_state)
          MAC: begin
            r_acc <= r_acc + ACC_W'(w_prod);
            r_k   <= w_last_k ? '0 : r_k + 1'b1;
          end
          SCALE: begin
            r_delta0[r_j] <= w_d0_new;
            r_res_valid   <= 1'b1;
            r_res_idx     <= r_j;
            r_acc         <= '0;
            if (!w_last_j) r_j <= r_j + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Status and result outputs.
  always_comb begin
    bus.busy      = (r_state == MAC) || (r_state == SCALE);
    bus.done      = (r_state == DONE);
    bus.res_valid = r_res_valid;
    bus.res_idx   = r_res_idx;
    bus.delta0    = r_delta0;
    for (int j = 0; j < N_HID; j++) bus.sign0[j] = r_delta0[j][W-1];
  end

endmodule

// File: tb/tb_hidden_delta_engine.sv
// Directed bench for hidden_delta_engine: default 5x3 build plus 1x1 and 8x4 builds.
module tb_hidden_delta_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  hidden_delta_engine_if #(.N_HID(5), .N_OUT(3), .W(10)) b0 ();
  hidden_delta_engine_if #(.N_HID(1), .N_OUT(1), .W(10)) b1 ();
  hidden_delta_engine_if #(.N_HID(8), .N_OUT(4), .W(10)) b2 ();

  hidden_delta_engine #(.N_HID(5), .N_OUT(3), .W(10), .FRAC(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  hidden_delta_engine #(.N_HID(1), .N_OUT(1), .W(10), .FRAC(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  hidden_delta_engine #(.N_HID(8), .N_OUT(4), .W(10), .FRAC(8)) u2 (.clk(clk), .rst(rst), .bus(b2));

  // Reference arithmetic for the 8x4 build.
  function automatic longint m_rnd(input longint x);
    return (x + 128) >>> 8;
  endfunction
  function automatic longint m_sat(input longint x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  task automatic set_in(input int d0, input int w0_all, input int oc_all);
    for (int k = 0; k < 3; k++) begin
      b0.delta1[k] = '0;
      for (int j = 0; j < 5; j++) b0.weight[k][j] = '0;
    end
    b0.delta1[0] = 10'(d0);
    for (int j = 0; j < 5; j++) begin
      b0.weight[0][j] = 10'(w0_all);
      b0.out_cal[j]   = 10'(oc_all);
    end
  endtask

  // Starts a run on b0 and waits for done; cyc = cycles after the accept edge, -1 on timeout.
  task automatic do_run(input bit hold, output int cyc, output int nval, output int idx_bad,
                        output logic busy0);
    b0.start = 1'b1;
    @(negedge clk);
    if (!hold) b0.start = 1'b0;
    busy0 = b0.busy;
    cyc = -1; nval = 0; idx_bad = 0;
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) @(negedge clk);
      if (b0.res_valid === 1'b1) begin
        if (int'(b0.res_idx) != nval) idx_bad++;
        nval++;
      end
      if (b0.done === 1'b1) begin
        cyc = c;
        break;
      end
    end
    b0.start = 1'b0;
  endtask

  task automatic test_reset();
    b0.start = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b0.start = 1'b0;
    n_checks++; if (b0.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", b0.busy); end
    n_checks++; if (b0.done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", b0.done); end
    n_checks++; if (b0.res_valid !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid got %b want 0", b0.res_valid); end
    n_checks++; if (b0.res_idx !== 3'd0) begin n_errors++; $display("FAIL reset_res_idx got %0d want 0", b0.res_idx); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== 10'sd0) begin n_errors++; $display("FAIL reset_delta0[%0d] got %0d want 0", j, b0.delta0[j]); end
    end
    n_checks++; if (b2.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy_8x4 got %b want 0", b2.busy); end
  endtask

  task automatic test_basic();
    int cyc, nval, bad; logic busy0;
    set_in(64, 128, 128);
    do_run(1'b0, cyc, nval, bad, busy0);
    n_checks++; if (busy0 !== 1'b1) begin n_errors++; $display("FAIL basic_busy_after_accept got %b want 1", busy0); end
    n_checks++; if (cyc != 20) begin n_errors++; $display("FAIL basic_latency got %0d want 20", cyc); end
    n_checks++; if (nval != 5) begin n_errors++; $display("FAIL basic_res_valid_count got %0d want 5", nval); end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL basic_res_idx_order got %0d bad want 0", bad); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== 10'sd8) begin n_errors++; $display("FAIL basic_delta0[%0d] got %0d want 8", j, b0.delta0[j]); end
    end
    n_checks++; if (b0.sign0 !== 5'b00000) begin n_errors++; $display("FAIL basic_sign0 got %b want 00000", b0.sign0); end
  endtask

  task automatic test_negative();
    int cyc, nval, bad; logic busy0;
    set_in(-64, 0, 128);
    b0.weight[0][0] = 10'sd128;
    do_run(1'b0, cyc, nval, bad, busy0);
    n_checks++; if (b0.delta0[0] !== -10'sd8) begin n_errors++; $display("FAIL neg_delta0[0] got %0d want -8", b0.delta0[0]); end
    n_checks++; if (b0.delta0[1] !== 10'sd0) begin n_errors++; $display("FAIL neg_delta0[1] got %0d want 0", b0.delta0[1]); end
    n_checks++; if (b0.sign0 !== 5'b00001) begin n_errors++; $display("FAIL neg_sign0 got %b want 00001", b0.sign0); end
  endtask

  task automatic test_saturation();
    int cyc, nval, bad; logic busy0;
    int oc  [5] = '{128, 0, 256, 128, 300};
    int exp_d [5] = '{128, 0, 0, 128, 0};
    logic signed [9:0] e;
    for (int k = 0; k < 3; k++) begin
      b0.delta1[k] = 10'sd511;
      for (int j = 0; j < 5; j++) b0.weight[k][j] = 10'sd511;
    end
    for (int j = 0; j < 5; j++) b0.out_cal[j] = 10'(oc[j]);
    do_run(1'b0, cyc, nval, bad, busy0);
    for (int j = 0; j < 5; j++) begin
      e = 10'(exp_d[j]);
      n_checks++;
      if (b0.delta0[j] !== e) begin n_errors++; $display("FAIL sat_delta0[%0d] got %0d want %0d", j, b0.delta0[j], e); end
    end
  endtask

  task automatic test_input_change();
    int cyc;
    set_in(64, 128, 128);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    set_in(-300, -77, 0);
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (b0.done === 1'b1) begin cyc = c; break; end
    end
    n_checks++; if (cyc != 20) begin n_errors++; $display("FAIL chg_latency got %0d want 20", cyc); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== 10'sd8) begin n_errors++; $display("FAIL chg_delta0[%0d] got %0d want 8", j, b0.delta0[j]); end
    end
  endtask

  task automatic test_start_held();
    int cyc, nval, bad, ndone; logic busy0;
    set_in(64, 128, 128);
    do_run(1'b1, cyc, nval, bad, busy0);
    n_checks++; if (cyc != 20) begin n_errors++; $display("FAIL held_latency got %0d want 20", cyc); end
    n_checks++; if (nval != 5) begin n_errors++; $display("FAIL held_res_valid_count got %0d want 5", nval); end
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (b0.done === 1'b1 || b0.busy === 1'b1) ndone++;
    end
    n_checks++; if (ndone != 0) begin n_errors++; $display("FAIL held_extra_activity got %0d cycles want 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int cyc, nval, bad; logic busy0;
    set_in(64, 128, 128);
    do_run(1'b0, cyc, nval, bad, busy0);
    b0.delta1[0] = -10'sd64;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    n_checks++; if (b0.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy_no_gap got %b want 1", b0.busy); end
    cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 4) begin
        n_checks++; if (b0.delta0[0] !== -10'sd8) begin n_errors++; $display("FAIL b2b_new_delta0[0] got %0d want -8", b0.delta0[0]); end
        n_checks++; if (b0.delta0[4] !== 10'sd8) begin n_errors++; $display("FAIL b2b_old_delta0[4] got %0d want 8", b0.delta0[4]); end
      end
      if (b0.done === 1'b1) begin cyc = c; break; end
    end
    n_checks++; if (cyc != 20) begin n_errors++; $display("FAIL b2b_latency got %0d want 20", cyc); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== -10'sd8) begin n_errors++; $display("FAIL b2b_delta0[%0d] got %0d want -8", j, b0.delta0[j]); end
    end
  endtask

  task automatic test_reset_midrun();
    int cyc, nval, bad, ndone; logic busy0;
    set_in(64, 128, 128);
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (b0.busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy got %b want 0", b0.busy); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== 10'sd0) begin n_errors++; $display("FAIL midrst_delta0[%0d] got %0d want 0", j, b0.delta0[j]); end
    end
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      if (b0.done === 1'b1) ndone++;
      @(negedge clk);
    end
    n_checks++; if (ndone != 0) begin n_errors++; $display("FAIL midrst_done_pulses got %0d want 0", ndone); end
    do_run(1'b0, cyc, nval, bad, busy0);
    n_checks++; if (cyc != 20) begin n_errors++; $display("FAIL midrst_rerun_latency got %0d want 20", cyc); end
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if (b0.delta0[j] !== 10'sd8) begin n_errors++; $display("FAIL midrst_rerun_delta0[%0d] got %0d want 8", j, b0.delta0[j]); end
    end
  endtask

  task automatic test_small();
    int cyc;
    b1.delta1[0] = -10'sd64;
    b1.weight[0][0] = 10'sd128;
    b1.out_cal[0] = 10'd128;
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (b1.done === 1'b1) begin cyc = c; break; end
    end
    n_checks++; if (cyc != 2) begin n_errors++; $display("FAIL small_latency got %0d want 2", cyc); end
    n_checks++; if (b1.delta0[0] !== -10'sd8) begin n_errors++; $display("FAIL small_delta0 got %0d want -8", b1.delta0[0]); end
    n_checks++; if (b1.sign0 !== 1'b1) begin n_errors++; $display("FAIL small_sign0 got %b want 1", b1.sign0); end
  endtask

  task automatic test_big();
    int cyc;
    int v;
    longint acc, s, c, sp;
    longint exp_d [8];
    logic signed [9:0] e;
    for (int run = 0; run < 3; run++) begin
      for (int k = 0; k < 4; k++) begin
        v = (run == 0) ? int'($urandom_range(0, 200)) - 100 : int'($urandom_range(0, 1023)) - 512;
        b2.delta1[k] = 10'(v);
        for (int j = 0; j < 8; j++) begin
          v = (run == 0) ? int'($urandom_range(0, 200)) - 100 : int'($urandom_range(0, 1023)) - 512;
          b2.weight[k][j] = 10'(v);
        end
      end
      for (int j = 0; j < 8; j++) b2.out_cal[j] = 10'($urandom_range(0, 300));
      for (int j = 0; j < 8; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(b2.delta1[k]) * longint'(b2.weight[k][j]);
        s  = m_sat(m_rnd(acc));
        c  = longint'(b2.out_cal[j]);
        if (c > 256) c = 256;
        sp = m_rnd(c * (256 - c));
        exp_d[j] = m_sat(m_rnd(s * sp));
      end
      b2.start = 1'b1;
      @(negedge clk);
      b2.start = 1'b0;
      set_big_garbage();
      cyc = -1;
      for (int cc = 1; cc <= 100; cc++) begin
        @(negedge clk);
        if (b2.done === 1'b1) begin cyc = cc; break; end
      end
      n_checks++; if (cyc != 40) begin n_errors++; $display("FAIL big%0d_latency got %0d want 40", run, cyc); end
      for (int j = 0; j < 8; j++) begin
        e = 10'(exp_d[j]);
        n_checks++;
        if (b2.delta0[j] !== e) begin n_errors++; $display("FAIL big%0d_delta0[%0d] got %0d want %0d", run, j, b2.delta0[j], e); end
        n_checks++;
        if (b2.sign0[j] !== e[9]) begin n_errors++; $display("FAIL big%0d_sign0[%0d] got %b want %b", run, j, b2.sign0[j], e[9]); end
      end
    end
  endtask

  task automatic set_big_garbage();
    for (int k = 0; k < 4; k++) begin
      b2.delta1[k] = 10'($urandom_range(0, 1023));
      for (int j = 0; j < 8; j++) b2.weight[k][j] = 10'($urandom_range(0, 1023));
    end
  endtask

  initial begin
    b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
    set_in(0, 0, 0);
    b1.delta1[0] = '0; b1.weight[0][0] = '0; b1.out_cal[0] = '0;
    for (int k = 0; k < 4; k++) begin
      b2.delta1[k] = '0;
      for (int j = 0; j < 8; j++) b2.weight[k][j] = '0;
    end
    for (int j = 0; j < 8; j++) b2.out_cal[j] = '0;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_input_change();
    test_start_held();
    test_back_to_back();
    test_reset_midrun();
    test_small();
    test_big();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
